// File: rtl/weight_axi_frontend.sv
// AXI4-Lite responder for the coupled-cell array: turns AW/W into a one-cycle
// cell weight-write strobe and AR into a registered cell readback.
module weight_axi_frontend #(
  parameter int N           = 8,
  parameter int NUM_WEIGHTS = 15,
  parameter int ADDR_W      = 16,
  parameter int CELL_W      = $clog2(N*N)
) (
  input  logic              clk,
  input  logic              axi_rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              weight_wr_en,
  output logic [CELL_W-1:0] weight_waddr,
  output logic [31:0]       weight_wdata,
  output logic [CELL_W-1:0] weight_raddr,
  input  logic [31:0]       weight_rdata
);
  localparam int                IDX_W  = ADDR_W - 2;
  localparam logic [IDX_W-1:0]  NCELLS = IDX_W'(N*N);
  localparam logic [1:0]        OKAY   = 2'b00;
  localparam logic [1:0]        SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP}   rstate_e;

  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (a[ADDR_W-1:2] < NCELLS);
  endfunction

  // ---------------- write path ----------------
  wstate_e             wstate_q, wstate_d;
  logic                aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                wstrb0_q, wstrb0_d;
  logic                wr_en_q, wr_en_d;
  logic [CELL_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_o_q, wdata_o_d;
  logic [1:0]          bresp_q, bresp_d;

  logic                aw_hs, w_hs, wr_ok;
  logic [ADDR_W-1:0]   awaddr_eff;
  logic [31:0]         wdata_eff;
  logic                wstrb0_eff;
  logic                unused_wstrb;

  assign unused_wstrb = ^s_wstrb[3:1];

  assign s_awready = (wstate_q == W_IDLE) && !aw_held_q && !axi_rst;
  assign s_wready  = (wstate_q == W_IDLE) && !w_held_q  && !axi_rst;
  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid  && s_wready;

  // Legality is judged on whichever copy is current: the held one, or the
  // one arriving in this very cycle when it completes the pair.
  assign awaddr_eff = aw_held_q ? awaddr_q : s_awaddr;
  assign wdata_eff  = w_held_q  ? wdata_q  : s_wdata;
  assign wstrb0_eff = w_held_q  ? wstrb0_q : s_wstrb[0];
  assign wr_ok      = addr_legal(awaddr_eff) && wstrb0_eff &&
                      (wdata_eff < 32'(NUM_WEIGHTS));

  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb0_d  = wstrb0_q;
    wr_en_d   = 1'b0;
    waddr_d   = waddr_q;
    wdata_o_d = wdata_o_q;
    bresp_d   = bresp_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_wdata;
          wstrb0_d = s_wstrb[0];
        end
        // Strobe and response are registered here so they are visible
        // throughout the single W_COMMIT cycle.
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          wstate_d = W_COMMIT;
          if (wr_ok) begin
            wr_en_d   = 1'b1;
            waddr_d   = awaddr_eff[CELL_W+1:2];
            wdata_o_d = wdata_eff;
            bresp_d   = OKAY;
          end else begin
            bresp_d   = SLVERR;
          end
        end
      end
      W_COMMIT: begin
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        wstate_d  = W_RESP;
      end
      W_RESP: begin
        if (s_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb0_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_o_q <= '0;
      bresp_q   <= OKAY;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb0_q  <= wstrb0_d;
      wr_en_q   <= wr_en_d;
      waddr_q   <= waddr_d;
      wdata_o_q <= wdata_o_d;
      bresp_q   <= bresp_d;
    end
  end

  assign s_bvalid     = (wstate_q == W_RESP);
  assign s_bresp      = bresp_q;
  assign weight_wr_en = wr_en_q;
  assign weight_waddr = waddr_q;
  assign weight_wdata = wdata_o_q;

  // ---------------- read path ----------------
  rstate_e           rstate_q, rstate_d;
  logic [CELL_W-1:0] raddr_q, raddr_d;
  logic              rlegal_q, rlegal_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              ar_legal;

  assign s_arready = (rstate_q == R_IDLE) && !axi_rst;
  assign ar_legal  = addr_legal(s_araddr);

  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rlegal_d = rlegal_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (s_arvalid && s_arready) begin
          rlegal_d = ar_legal;
          raddr_d  = ar_legal ? s_araddr[CELL_W+1:2] : '0;
          rstate_d = R_WAIT;
        end
      end
      R_WAIT: begin
        // The array mux settles within this cycle of the new raddr.
        rdata_d  = rlegal_q ? weight_rdata : 32'd0;
        rresp_d  = rlegal_q ? OKAY : SLVERR;
        rstate_d = R_RESP;
      end
      R_RESP: begin
        if (s_rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rlegal_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rlegal_q <= rlegal_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign s_rvalid     = (rstate_q == R_RESP);
  assign s_rdata      = rdata_q;
  assign s_rresp      = rresp_q;
  assign weight_raddr = raddr_q;

endmodule

// File: tb/tb_weight_axi_frontend.sv
// Randomized bench for weight_axi_frontend: a stand-in cell array plus a
// reference model of which writes land and what each read must return.
module tb_weight_axi_frontend;
  localparam int NC = 64;
  localparam int NW = 15;

  logic        clk = 1'b0;
  logic        axi_rst;
  logic [15:0] s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic        weight_wr_en;
  logic [5:0]  weight_waddr, weight_raddr;
  logic [31:0] weight_wdata, weight_rdata;

  weight_axi_frontend dut (
    .clk(clk), .axi_rst(axi_rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .weight_wr_en(weight_wr_en), .weight_waddr(weight_waddr),
    .weight_wdata(weight_wdata), .weight_raddr(weight_raddr),
    .weight_rdata(weight_rdata)
  );

  always #5 clk = ~clk;

  // Stand-in cell array: combinational readback mux, written by the strobe.
  logic [31:0] mem [NC];
  logic        clr_mem;
  int          strobe_cnt = 0;
  assign weight_rdata = mem[weight_raddr];

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < NC; i++) mem[i] <= 32'd0;
    end else if (!axi_rst && weight_wr_en) begin
      mem[weight_waddr] <= weight_wdata;
      strobe_cnt <= strobe_cnt + 1;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [NC];
  logic [31:0] last_waddr, last_wdata;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic bit m_legal(input logic [15:0] a);
    return (a % 4 == 0) && (a / 4 < NC);
  endfunction

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w, ok;
    int cyc = 0, sc0;
    logic [1:0] exp_resp;
    ok = m_legal(addr) && strb[0] && (data < NW);
    exp_resp = ok ? 2'b00 : 2'b10;
    sc0 = strobe_cnt;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      s_awvalid = !aw_done && (cyc >= aw_dly);
      s_wvalid  = !w_done  && (cyc >= w_dly);
      @(negedge clk);
      if (w_done && !aw_done) chk("wready_after_w", s_wready, 0);
      if (aw_done && !w_done) chk("awready_after_aw", s_awready, 0);
      hs_aw = s_awvalid && s_awready;
      hs_w  = s_wvalid && s_wready;
      @(posedge clk); #1;
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done = 1;
      cyc++;
    end
    s_awvalid = 0; s_wvalid = 0;
    chk("write_hs_done", {aw_done, w_done}, 2'b11);
    @(negedge clk);
    chk("commit_wr_en", weight_wr_en, ok);
    chk("commit_waddr", weight_waddr, ok ? 32'(addr / 4) : last_waddr);
    chk("commit_wdata", weight_wdata, ok ? data : last_wdata);
    chk("commit_bvalid", s_bvalid, 0);
    chk("commit_awready", s_awready, 0);
    if (ok) begin
      ref_mem[addr / 4] = data;
      last_waddr = 32'(addr / 4);
      last_wdata = data;
    end
    @(posedge clk); #1;
    for (int i = 0; i <= b_dly; i++) begin
      s_bready = (i == b_dly);
      @(negedge clk);
      chk("bvalid", s_bvalid, 1);
      chk("bresp", s_bresp, exp_resp);
      chk("b_wr_en_low", weight_wr_en, 0);
      chk("b_awready", s_awready, 0);
      chk("b_wready", s_wready, 0);
      @(posedge clk); #1;
    end
    s_bready = 0;
    @(negedge clk);
    chk("bvalid_clear", s_bvalid, 0);
    chk("strobe_count", 32'(strobe_cnt - sc0), ok);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [15:0] addr, input int ar_dly, input int r_dly);
    bit done = 0, hs, ok;
    int cyc = 0;
    logic [31:0] exp_d;
    ok = m_legal(addr);
    exp_d = 32'd0;
    if (ok) exp_d = ref_mem[addr / 4];
    s_araddr = addr;
    while (!done && cyc < 50) begin
      s_arvalid = (cyc >= ar_dly);
      @(negedge clk);
      hs = s_arvalid && s_arready;
      @(posedge clk); #1;
      if (hs) done = 1;
      cyc++;
    end
    s_arvalid = 0;
    chk("read_hs_done", done, 1);
    @(negedge clk);
    chk("raddr", weight_raddr, ok ? 32'(addr / 4) : 32'd0);
    chk("rvalid_wait", s_rvalid, 0);
    @(posedge clk); #1;
    for (int i = 0; i <= r_dly; i++) begin
      s_rready = (i == r_dly);
      @(negedge clk);
      chk("rvalid", s_rvalid, 1);
      chk("rdata", s_rdata, exp_d);
      chk("rresp", s_rresp, ok ? 2'b00 : 2'b10);
      @(posedge clk); #1;
    end
    s_rready = 0;
    @(negedge clk);
    chk("rvalid_clear", s_rvalid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int sc0;
    s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0;
    s_bready = 0; s_araddr = 0; s_arvalid = 0; s_rready = 0;
    for (int i = 0; i < NC; i++) ref_mem[i] = 32'd0;
    last_waddr = 0; last_wdata = 0;
    axi_rst = 1; clr_mem = 1;
    repeat (3) @(posedge clk);
    #1 clr_mem = 0;
    @(negedge clk);
    chk("rst_awready", s_awready, 0);
    chk("rst_wready", s_wready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_wr_en", weight_wr_en, 0);
    chk("rst_waddr", weight_waddr, 0);
    chk("rst_wdata", weight_wdata, 0);
    chk("rst_raddr", weight_raddr, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_resp", {s_bresp, s_rresp}, 0);
    axi_rst = 0;
    @(posedge clk); #1;

    do_write(16'h0014, 3,  4'hF, 0, 0, 0);
    do_write(16'h0000, 12, 4'hF, 3, 0, 0);
    do_write(16'h0014, 15, 4'hF, 0, 0, 0);
    do_write(16'h0102, 1,  4'hF, 0, 0, 0);
    do_write(16'h0100, 2,  4'hF, 0, 0, 0);
    do_write(16'h0008, 2,  4'hE, 0, 0, 0);
    do_write(16'h00FC, 9,  4'hF, 1, 2, 5);
    do_read(16'h00FC, 0, 5);
    do_read(16'h0100, 0, 0);
    do_read(16'h0014, 2, 1);

    // Reset landing in the commit cycle must drop the write entirely.
    sc0 = strobe_cnt;
    s_awaddr = 16'h0020; s_wdata = 5; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1;
    @(negedge clk);
    chk("mid_awready", s_awready, 1);
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0;
    @(negedge clk);
    chk("mid_commit_wr_en", weight_wr_en, 1);
    axi_rst = 1;
    #1;
    chk("mid_rst_wr_en", weight_wr_en, 0);
    chk("mid_rst_bvalid", s_bvalid, 0);
    chk("mid_rst_awready", s_awready, 0);
    chk("mid_rst_waddr", weight_waddr, 0);
    repeat (2) @(posedge clk);
    #1 axi_rst = 0;
    last_waddr = 0; last_wdata = 0;
    @(negedge clk);
    chk("mid_no_bvalid", s_bvalid, 0);
    chk("mid_no_strobe", 32'(strobe_cnt - sc0), 0);
    @(posedge clk); #1;
    do_write(16'h0004, 7, 4'hF, 0, 0, 0);
    do_read(16'h0004, 0, 0);
    do_read(16'h0020, 0, 0);

    for (int k = 0; k < 80; k++) begin
      a = 16'($urandom_range(0, 70) * 4);
      if ($urandom_range(0, 7) == 0) a = a | 16'($urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) begin
        do_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
      end else begin
        d = $urandom_range(0, 17);
        s = 4'($urandom) | 4'h1;
        if ($urandom_range(0, 6) == 0) s = s & 4'hE;
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end
    for (int c = 0; c < NC; c += 9) do_read(16'(c * 4), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/weight_axi_frontend.md
Name: weight_axi_frontend

Overview:
- AXI4-Lite responder that fronts the N×N coupled-cell array and drives the synchronous weight-write and readback interface of every cell.
- Decodes the AW/W channels into a one-cycle cell write strobe, a cell index and data, then returns a B response.
- Serves AR/R reads by driving a cell read index and registering the muxed cell readback.
- Sits between the SoC AXI interconnect and the array; each cell compares `weight_waddr` against its own index to form its address match.

Parameters:
- N, 8: array dimension; the array has N*N cells.
- NUM_WEIGHTS, 15: number of legal weight codes. Must be odd. Legal codes are 0..NUM_WEIGHTS-1.
- ADDR_W, 16: AXI address width.
- CELL_W, $clog2(N*N): cell index width.

Ports:
- clk  in  1  AXI/system clock
- axi_rst  in  1  asynchronous active-high reset
- s_awaddr  in  ADDR_W  write address
- s_awvalid  in  1
- s_awready  out  1
- s_wdata  in  32
- s_wstrb  in  4
- s_wvalid  in  1
- s_wready  out  1
- s_bresp  out  2  00 = OKAY, 10 = SLVERR
- s_bvalid  out  1
- s_bready  in  1
- s_araddr  in  ADDR_W
- s_arvalid  in  1
- s_arready  out  1
- s_rdata  out  32
- s_rresp  out  2
- s_rvalid  out  1
- s_rready  in  1
- weight_wr_en  out  1  one-cycle write strobe to the array
- weight_waddr  out  CELL_W  target cell index = row*N + col
- weight_wdata  out  32  write data, broadcast to all cells
- weight_raddr  out  CELL_W  readback cell index
- weight_rdata  in  32  muxed cell readback, valid 1 cycle after `weight_raddr` changes

Behaviour:
- **Address map:** cell index = awaddr[ADDR_W-1:2]. The address is legal iff awaddr[1:0]==0 and index < N*N.
- **Reset:** axi_rst asserted forces the following, asynchronously:
  - all valids = 0; s_bresp = s_rresp = 0; s_rdata = 0;
  - weight_wr_en = 0; weight_waddr = weight_raddr = 0; weight_wdata = 0;
  - both FSMs to IDLE; AW-held and W-held flags cleared.
  - s_awready, s_wready and s_arready are forced 0 while axi_rst is high.
- **Write FSM (states W_IDLE, W_COMMIT, W_RESP):**
  - W_IDLE: s_awready = !aw_held; s_wready = !w_held. AW and W handshakes are captured independently, in either order or the same cycle.
  - When both are held (including the cycle both are captured), the next state is W_COMMIT.
  - W_COMMIT (exactly 1 cycle): the write is valid iff the address is legal, s_wstrb[0]==1 and wdata < NUM_WEIGHTS.
    - Valid write: weight_wr_en=1, weight_waddr=index, weight_wdata=wdata, bresp=OKAY.
    - Otherwise: weight_wr_en stays 0, weight_waddr/weight_wdata keep their previous values, bresp=SLVERR.
    - Held flags clear; go to W_RESP.
  - W_RESP: s_bvalid=1 until s_bready is sampled high, then W_IDLE. No new AW/W is accepted in W_COMMIT or W_RESP.
  - Latency: the strobe occurs 1 cycle after the second handshake; bvalid rises 2 cycles after it.
- **Read FSM (states R_IDLE, R_WAIT, R_RESP):**
  - R_IDLE: s_arready=1. On handshake, weight_raddr = index (0 if the address is illegal); go to R_WAIT.
  - R_WAIT (1 cycle): capture s_rdata = weight_rdata if legal, else 0 with SLVERR; go to R_RESP.
  - R_RESP: s_rvalid=1; s_rdata and s_rresp are held stable until s_rready, then R_IDLE.
- **Read/write independence:** the read and write FSMs are independent. A read of cell k in the same cycle as a write to cell k returns either the old or the new value. A read issued after bvalid has been accepted returns the new value.
- **Stall behaviour:** all outputs are held stable under backpressure. A valid that arrives without its matching handshake partner waits indefinitely.
- **Reset mid-transaction:** an in-flight transaction is dropped; no strobe is issued and no response is returned.

Test Plan:
- **Simultaneous AW+W:** awaddr=0x0014, wdata=3, wstrb=0xF → weight_wr_en high for exactly 1 cycle with weight_waddr=5, weight_wdata=3; then bvalid with bresp=00.
- **Out-of-order channels:** W (wdata=12) arrives 3 cycles before AW (awaddr=0x0000) → s_wready drops after the W capture; strobe fires 1 cycle after the AW handshake with index 0 and data 12.
- **Illegal writes → bresp=10, no strobe:**
  - wdata=15 (≥ NUM_WEIGHTS);
  - awaddr=0x0102 (misaligned);
  - awaddr=0x0100 (index 64 ≥ N*N=64);
  - wstrb=0xE.
- **Readback after write:** write 9 to cell 63 (0x00FC), then read 0x00FC with a model array → rdata=9, rresp=00. Read 0x0100 → rdata=0, rresp=10.
- **Backpressure:** hold bready=0 for 5 cycles and rready=0 for 5 cycles → bvalid, rvalid, rdata and resp stay stable; no second AW/W is accepted until B completes.
- **Reset mid-operation:** assert axi_rst in W_COMMIT → weight_wr_en and bvalid go 0 immediately. After release, a new write to cell 1 completes normally.
